// File: rtl/anticipated_carry_adder.sv
// Block-lookahead adder: combinational sum/cout plus a registered copy.
// Optional signed-overflow outputs (ovf, ovf_q) when ANTICIPATED_CARRY_ADDER_OVF_EN is defined.
module anticipated_carry_adder #(
    parameter int unsigned width       = 8,
    parameter int unsigned block_width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout,
    output logic [width-1:0] sum_q,
    output logic             cout_q
`ifdef ANTICIPATED_CARRY_ADDER_OVF_EN
    ,
    output logic             ovf,
    output logic             ovf_q
`endif
);

    localparam int unsigned num_blocks = (block_width == 0) ? 1 : width / block_width;

    if (width == 0 || block_width == 0 || (width % block_width) != 0) begin : g_bad_cfg
        $error("anticipated_carry_adder: width must be a positive multiple of block_width");
    end

    logic [width-1:0]    g;
    logic [width-1:0]    p;
    logic [width:0]      c;
    logic [num_blocks-1:0] blk_g;
    logic [num_blocks-1:0] blk_p;
    logic [num_blocks:0]   blk_c;

    // Block G/P, block-level carry chain, then in-block lookahead from each block carry-in.
    always_comb begin
        logic gg;
        logic pp;
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        blk_g = '0;
        blk_p = '0;
        blk_c = '0;
        gg    = 1'b0;
        pp    = 1'b1;
        blk_c[0] = cin;
        for (int unsigned k = 0; k < num_blocks; k++) begin
            blk_g[k] = 1'b0;
            blk_p[k] = 1'b1;
            for (int unsigned i = 0; i < block_width; i++) begin
                blk_g[k] = g[k*block_width + i] | (p[k*block_width + i] & blk_g[k]);
                blk_p[k] = blk_p[k] & p[k*block_width + i];
            end
            blk_c[k+1] = blk_g[k] | (blk_p[k] & blk_c[k]);
        end
        for (int unsigned k = 0; k < num_blocks; k++) begin
            for (int unsigned j = 0; j < block_width; j++) begin
                // Group G/P over the bits below j inside this block.
                gg = 1'b0;
                pp = 1'b1;
                for (int unsigned i = 0; i < j; i++) begin
                    gg = g[k*block_width + i] | (p[k*block_width + i] & gg);
                    pp = pp & p[k*block_width + i];
                end
                c[k*block_width + j] = gg | (pp & blk_c[k]);
            end
        end
        c[width] = blk_c[num_blocks];
    end

    assign sum  = p ^ c[width-1:0];
    assign cout = c[width];

    logic [width-1:0] sum_d;
    logic             cout_d;

    always_comb begin
        sum_d  = sum;
        cout_d = cout;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

`ifdef ANTICIPATED_CARRY_ADDER_OVF_EN
    logic ovf_d;

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign ovf = c[width-1] ^ c[width];

    always_comb begin
        ovf_d = ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_anticipated_carry_adder.sv
// Scoreboard bench for anticipated_carry_adder (width=8, block_width=4).
module tb_anticipated_carry_adder;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic [7:0] sum_q;
    logic       cout_q;
`ifdef ANTICIPATED_CARRY_ADDER_OVF_EN
    logic       ovf;
    logic       ovf_q;
`endif

    anticipated_carry_adder #(.width(8), .block_width(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .sum_q  (sum_q),
        .cout_q (cout_q)
`ifdef ANTICIPATED_CARRY_ADDER_OVF_EN
        ,
        .ovf    (ovf),
        .ovf_q  (ovf_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         cyc;
    } exp_t;

    typedef struct {
        logic       rst_n;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    exp_t comb_q[$];
    exp_t reg_q[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    initial begin
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] ripple(input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [8:0] r;
        logic       cc;
        cc = ci;
        r  = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (x[i] & cc) | (y[i] & cc);
        end
        r[8] = cc;
        return r;
    endfunction

    // Monitor: combinational results of this cycle, registered results of the previous one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (comb_q.size() > 0 && comb_q[0].cyc <= cyc) begin
                e = comb_q.pop_front();
                n_cmp++;
                if (sum !== e.s || cout !== e.co) begin
                    n_bad++;
                    $display("FAIL comb cyc=%0d: got sum=%h cout=%b, want sum=%h cout=%b",
                             e.cyc, sum, cout, e.s, e.co);
                end
`ifdef ANTICIPATED_CARRY_ADDER_OVF_EN
                n_cmp++;
                if (ovf !== e.ov) begin
                    n_bad++;
                    $display("FAIL ovf cyc=%0d: got %b want %b", e.cyc, ovf, e.ov);
                end
`endif
            end
            while (reg_q.size() > 0 && reg_q[0].cyc < cyc) begin
                e = reg_q.pop_front();
                n_cmp++;
                if (sum_q !== e.s || cout_q !== e.co) begin
                    n_bad++;
                    $display("FAIL reg cyc=%0d: got sum_q=%h cout_q=%b, want sum_q=%h cout_q=%b",
                             e.cyc, sum_q, cout_q, e.s, e.co);
                end
`ifdef ANTICIPATED_CARRY_ADDER_OVF_EN
                n_cmp++;
                if (ovf_q !== e.ov) begin
                    n_bad++;
                    $display("FAIL ovf_q cyc=%0d: got %b want %b", e.cyc, ovf_q, e.ov);
                end
`endif
            end
        end
    end

    vec_t vecs[14];

    initial begin
        logic [8:0] rm;
        logic [8:0] bm;
        exp_t       ec;
        exp_t       er;

        //           rst   a      b      cin   sum    cout  ovf
        vecs[0]  = '{1'b0, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 8'h3C, 8'hA5, 1'b0, 8'hE1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'h07, 8'h09, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;

        // Exhaustive combinational sweep, cin=0, against ripple and behavioural models.
        for (int i = 0; i < 65536; i++) begin
            a   = 8'(i >> 8);
            b   = 8'(i);
            #1;
            rm = ripple(a, b, 1'b0);
            bm = 9'(a) + 9'(b);
            n_cmp++;
            if ({cout, sum} !== rm || {cout, sum} !== bm) begin
                n_bad++;
                $display("FAIL exhaustive a=%h b=%h: got %h, want ripple %h / behavioural %h",
                         a, b, {cout, sum}, rm, bm);
            end
        end

        // Clocked directed phase.
        for (int v = 0; v < 14; v++) begin
            @(posedge clk);
            #2;
            rst_n = vecs[v].rst_n;
            a     = vecs[v].a;
            b     = vecs[v].b;
            cin   = vecs[v].cin;
            ec.s   = vecs[v].s;
            ec.co  = vecs[v].co;
            ec.ov  = vecs[v].ov;
            ec.cyc = cyc;
            comb_q.push_back(ec);
            er.s   = vecs[v].rst_n ? vecs[v].s  : 8'h00;
            er.co  = vecs[v].rst_n ? vecs[v].co : 1'b0;
            er.ov  = vecs[v].rst_n ? vecs[v].ov : 1'b0;
            er.cyc = cyc;
            reg_q.push_back(er);
        end

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (comb_q.size() != 0 || reg_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d entries left, want 0/0", comb_q.size(), reg_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
